// File: rtl/mul_div_seq.sv
// mul_div_seq: iterative radix-2 multiply/divide unit with a start/busy/done handshake.
// UMUL/SMUL use LSB-first shift-add over WIDTH cycles. UDIV/SDIV use MSB-first
// restoring shift-subtract over WIDTH cycles. One FIXUP cycle then applies the
// result signs.
// Build option MDU_DIV_EN: when defined, the divider datapath is present. When it is
// undefined, divide ops go straight to DONE with zero results.
module mul_div_seq #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result_lo,
    output logic [WIDTH-1:0] result_hi,
    output logic             div_by_zero
);
    localparam int            CW         = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST_COUNT = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        CALC  = 2'd1,
        FIXUP = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t           state_reg, state_next;
    logic [CW-1:0]    count_reg;
    logic [WIDTH-1:0] acc_hi_reg;      // product high half / partial remainder
    logic [WIDTH-1:0] acc_lo_reg;      // multiplier bits / dividend bits -> quotient
    logic [WIDTH-1:0] opnd_reg;        // |multiplicand| or |divisor|
    logic             neg_lo_reg;      // negate product, or negate quotient
    logic [WIDTH-1:0] result_lo_reg;
    logic [WIDTH-1:0] result_hi_reg;
    logic             div_by_zero_reg;
`ifdef MDU_DIV_EN
    logic             is_div_reg;      // latched op[1]; selects the CALC step
    logic             neg_hi_reg;      // remainder follows the dividend sign
    logic [WIDTH-1:0] a_orig_reg;      // returned as remainder on divide by zero
`endif

    // Signed ops work on magnitudes. |MIN| still fits in WIDTH unsigned bits.
    logic             sign_a, sign_b;
    logic [WIDTH-1:0] mag_a, mag_b;
    assign sign_a = op[0] & a[WIDTH-1];
    assign sign_b = op[0] & b[WIDTH-1];
    assign mag_a  = sign_a ? -a : a;
    assign mag_b  = sign_b ? -b : b;

    // Shift-add step: conditionally add the multiplicand, then shift {hi,lo} right.
    logic [WIDTH:0] mul_sum;
    assign mul_sum = {1'b0, acc_hi_reg} + (acc_lo_reg[0] ? {1'b0, opnd_reg} : {(WIDTH + 1){1'b0}});

    // The product is negated as one 2*WIDTH quantity so the high half is sign-correct.
    logic [2*WIDTH-1:0] product, product_fix;
    assign product     = {acc_hi_reg, acc_lo_reg};
    assign product_fix = neg_lo_reg ? -product : product;

`ifdef MDU_DIV_EN
    // Restoring step: bring in the next dividend bit and try to subtract the divisor.
    // Bit WIDTH of the difference is the borrow, because the remainder is always below the divisor.
    logic [WIDTH:0] div_shift, div_diff;
    logic           div_fits;
    assign div_shift = {acc_hi_reg, acc_lo_reg[WIDTH-1]};
    assign div_diff  = div_shift - {1'b0, opnd_reg};
    assign div_fits  = ~div_diff[WIDTH];
`endif

    // State register; reset aborts any operation in flight.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // Next-state and handshake outputs; start is only looked at when not busy.
    always_comb begin
        state_next = state_reg;
        busy       = 1'b0;
        done       = 1'b0;
        case (state_reg)
            IDLE, DONE: begin
                done = (state_reg == DONE);
                if (start) begin
`ifdef MDU_DIV_EN
                    state_next = CALC;
`else
                    state_next = op[1] ? DONE : CALC;
`endif
                end else begin
                    state_next = IDLE;
                end
            end
            CALC: begin
                busy = 1'b1;
                if (count_reg == LAST_COUNT) begin
                    state_next = FIXUP;
                end
            end
            FIXUP: begin
                busy       = 1'b1;
                state_next = DONE;
            end
            default: state_next = IDLE;
        endcase
    end

    // Datapath: latch operands on acceptance, iterate in CALC, publish results in FIXUP.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count_reg       <= '0;
            acc_hi_reg      <= '0;
            acc_lo_reg      <= '0;
            opnd_reg        <= '0;
            neg_lo_reg      <= 1'b0;
            result_lo_reg   <= '0;
            result_hi_reg   <= '0;
            div_by_zero_reg <= 1'b0;
`ifdef MDU_DIV_EN
            is_div_reg      <= 1'b0;
            neg_hi_reg      <= 1'b0;
            a_orig_reg      <= '0;
`endif
        end else begin
            case (state_reg)
                IDLE, DONE: begin
                    if (start) begin
                        count_reg       <= '0;
                        acc_hi_reg      <= '0;
                        neg_lo_reg      <= sign_a ^ sign_b;
                        div_by_zero_reg <= 1'b0;
`ifdef MDU_DIV_EN
                        is_div_reg      <= op[1];
                        neg_hi_reg      <= op[1] & sign_a;
                        a_orig_reg      <= a;
                        acc_lo_reg      <= op[1] ? mag_a : mag_b;
                        opnd_reg        <= op[1] ? mag_b : mag_a;
`else
                        acc_lo_reg      <= mag_b;
                        opnd_reg        <= mag_a;
                        // Divide is absent: the op completes at once with zero results.
                        if (op[1]) begin
                            result_lo_reg <= '0;
                            result_hi_reg <= '0;
                        end
`endif
                    end
                end
                CALC: begin
                    count_reg <= count_reg + CW'(1);
`ifdef MDU_DIV_EN
                    if (is_div_reg) begin
                        acc_hi_reg <= div_fits ? div_diff[WIDTH-1:0] : div_shift[WIDTH-1:0];
                        acc_lo_reg <= {acc_lo_reg[WIDTH-2:0], div_fits};
                    end else begin
                        acc_hi_reg <= mul_sum[WIDTH:1];
                        acc_lo_reg <= {mul_sum[0], acc_lo_reg[WIDTH-1:1]};
                    end
`else
                    acc_hi_reg <= mul_sum[WIDTH:1];
                    acc_lo_reg <= {mul_sum[0], acc_lo_reg[WIDTH-1:1]};
`endif
                end
                FIXUP: begin
`ifdef MDU_DIV_EN
                    if (is_div_reg) begin
                        if (opnd_reg == '0) begin
                            result_lo_reg   <= '1;
                            result_hi_reg   <= a_orig_reg;
                            div_by_zero_reg <= 1'b1;
                        end else begin
                            result_lo_reg <= neg_lo_reg ? -acc_lo_reg : acc_lo_reg;
                            result_hi_reg <= neg_hi_reg ? -acc_hi_reg : acc_hi_reg;
                        end
                    end else begin
                        result_lo_reg <= product_fix[WIDTH-1:0];
                        result_hi_reg <= product_fix[2*WIDTH-1:WIDTH];
                    end
`else
                    result_lo_reg <= product_fix[WIDTH-1:0];
                    result_hi_reg <= product_fix[2*WIDTH-1:WIDTH];
`endif
                end
                default: ;
            endcase
        end
    end

    assign result_lo   = result_lo_reg;
    assign result_hi   = result_hi_reg;
    assign div_by_zero = div_by_zero_reg;

endmodule
